// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
//   state_e   : sequencer FSM states
//   NDefault  : default multiplier operand width / iteration count
//   cnt_width : width of the iteration counter for a given operand width
package mult_pkg;

  localparam int unsigned NDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAdd,
    StShift,
    StHalt
  } state_e;

  // $clog2(1) is 0; keep at least one bit so the counter stays a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier sequencer.
//   Clk, Reset : clock and synchronous active-high reset (clears the count)
//   clr_i      : synchronous clear to zero
//   inc_i      : increment by one; saturates at N-1 so the count never wraps
//   cnt_o      : current iteration number
//   term_o     : high when cnt_o == N-1 (last iteration)
module iter_counter
  import mult_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [cnt_width(N)-1:0] cnt_o,
  output logic                    term_o
);

  localparam int unsigned CntW = cnt_width(N);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == CntW'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !term_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for an N-bit Booth-style shift-add multiplier datapath (X:A:B chain).
//   Clk, Reset   : clock and synchronous active-high reset
//   Run          : level start request; a held Run produces exactly one run
//   ClearA_LoadB : operator request (honoured only in IDLE) to clear A/X and load B
//   M            : current LSB of B (multiplier bit)
//   Clr_Ld       : clear A/X, load B (combinational in IDLE)
//   Clear_AX     : clear A/X at run start
//   Add / Sub    : load A/X with A+S / A-S; Sub only on the last (sign) iteration
//   Shift        : arithmetic right shift of X:A:B
//   Busy / Done  : run in progress / result ready (HALT)
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clear_AX,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic            cnt_clr, cnt_inc, cnt_last;
  logic [CntW-1:0] cnt;

  iter_counter #(
    .N (N)
  ) u_iter_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .term_o (cnt_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    Clr_Ld   = 1'b0;
    Clear_AX = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift    = 1'b0;
    Busy     = 1'b1;
    Done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        Busy = 1'b0;
        // Operator load wins over Run in the same cycle.
        if (ClearA_LoadB) begin
          Clr_Ld = 1'b1;
        end else if (Run) begin
          state_d = StClear;
        end
      end
      StClear: begin
        Clear_AX = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = StAdd;
      end
      StAdd: begin
        // The last multiplier bit carries negative weight in two's complement.
        Add     = M & ~cnt_last;
        Sub     = M & cnt_last;
        state_d = StShift;
      end
      StShift: begin
        Shift = 1'b1;
        if (cnt_last) begin
          state_d = StHalt;
        end else begin
          cnt_inc = 1'b1;
          state_d = StAdd;
        end
      end
      StHalt: begin
        Busy = 1'b0;
        Done = 1'b1;
        // Wait for Run to drop so a held request cannot retrigger.
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The counter saturates at N-1; anything larger means corrupted state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      assert (int'(cnt) <= int'(N) - 1)
        else $error("iteration counter out of range: %0d", cnt);
    end
  end

endmodule
